burst_bram_writer: RTL and testbench

BURST_BRAM_WRITER -- requirements
Module: burst_bram_writer

---
 rtl/burst_bram_writer_if.sv | 42 ++++
 rtl/burst_bram_writer.sv | 120 ++++++++++++
 tb/tb_burst_bram_writer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/burst_bram_writer_if.sv
// Command FIFO, data FIFO and BRAM write port bundle for burst_bram_writer.
// master: the burst writer itself; slave: the FIFOs/BRAM side it talks to.
interface burst_bram_writer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_BITS  = 10,
  parameter int unsigned LEN_BITS   = 4
);
  // Command FIFO read side
  logic                  cmd_nempty;
  logic                  cmd_re;
  logic [ADDR_BITS-1:0]  cmd_addr;
  logic [LEN_BITS-1:0]   cmd_len;
  logic                  cmd_fixed;
  // Data FIFO read side
  logic                  wd_nempty;
  logic                  wd_re;
  logic [DATA_WIDTH-1:0] wd_data;
  logic                  wd_last;
  // BRAM write port and status
  logic                  bram_we;
  logic [ADDR_BITS-1:0]  bram_addr;
  logic [DATA_WIDTH-1:0] bram_wdata;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    input  cmd_nempty, cmd_addr, cmd_len, cmd_fixed,
    input  wd_nempty, wd_data, wd_last,
    output cmd_re, wd_re,
    output bram_we, bram_addr, bram_wdata,
    output busy, done, err
  );

  modport slave (
    output cmd_nempty, cmd_addr, cmd_len, cmd_fixed,
    output wd_nempty, wd_data, wd_last,
    input  cmd_re, wd_re,
    input  bram_we, bram_addr, bram_wdata,
    input  busy, done, err
  );
endinterface

// File: rtl/burst_bram_writer.sv
// Pops burst commands and data words from two FIFOs and writes each beat
// into a BRAM, INCR or FIXED addressing, flagging wd_last mismatches.
module burst_bram_writer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_BITS  = 10,
  parameter int unsigned LEN_BITS   = 4
) (
  input  logic               clk,
  input  logic               rst,
  burst_bram_writer_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [LEN_BITS-1:0]   len_q, len_d;
  logic                  fixed_q, fixed_d;
  logic [LEN_BITS-1:0]   cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  we_q, we_d;
  logic [ADDR_BITS-1:0]  baddr_q, baddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic cmd_pop;
  logic wd_pop;
  logic final_beat;

  // Pops are gated by state, so cmd_re and wd_re can never coincide, and by rst.
  assign cmd_pop    = (state_q == S_IDLE) && bus.cmd_nempty && !rst;
  assign wd_pop     = (state_q == S_DATA) && bus.wd_nempty && !rst;
  // Counter compare (not a count-down) keeps len = all-ones at 2^LEN_BITS beats;
  // the counter wraps to zero on that last beat, which is never looked at again.
  assign final_beat = (cnt_q == len_q);

  assign bus.cmd_re     = cmd_pop;
  assign bus.wd_re      = wd_pop;
  assign bus.bram_we    = we_q;
  assign bus.bram_addr  = baddr_q;
  assign bus.bram_wdata = wdata_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.err        = (state_q == S_DONE) && err_q;

  // Next-state: command latch in IDLE, one beat per data pop in DATA.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    fixed_d = fixed_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    we_d    = 1'b0;
    baddr_d = baddr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_pop) begin
          addr_d  = bus.cmd_addr;
          len_d   = bus.cmd_len;
          fixed_d = bus.cmd_fixed;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (wd_pop) begin
          we_d    = 1'b1;
          baddr_d = addr_q;
          wdata_d = bus.wd_data;
          if (!fixed_q) begin
            addr_d = addr_q + 1'b1;
          end
          cnt_d = cnt_q + 1'b1;
          if (bus.wd_last != final_beat) begin
            err_d = 1'b1;
          end
          if (final_beat) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and write-port registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      fixed_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      baddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      fixed_q <= fixed_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      we_q    <= we_d;
      baddr_q <= baddr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_burst_bram_writer.sv
// Directed bench for burst_bram_writer: queue-backed FIFO models, per-cycle
// logging of pops/writes/done, hand-computed expectations per scenario.
module tb_burst_bram_writer;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 10;
  localparam int unsigned LW = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic          fixed;
  } cmd_t;
  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } wd_t;
  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  typedef struct {
    int   cyc;
    logic err;
  } dn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_v = 1'b1;
  always #5 clk = ~clk;

  burst_bram_writer_if #(.DATA_WIDTH(DW), .ADDR_BITS(AW), .LEN_BITS(LW)) bus ();

  burst_bram_writer #(.DATA_WIDTH(DW), .ADDR_BITS(AW), .LEN_BITS(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  cmd_t cmd_q[$];
  wd_t  wd_q[$];
  wr_t  wr_log[$];
  dn_t  dn_log[$];
  int   cre_log[$];
  logic busy_log [0:4095];
  int   cyc      = 0;
  int   overlap  = 0;
  int   bad_pop  = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   k;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive FIFO heads at negedge, then log outputs and pops.
  task automatic step();
    @(negedge clk);
    rst = rst_v;
    bus.cmd_nempty = (cmd_q.size() != 0);
    if (cmd_q.size() != 0) {bus.cmd_addr, bus.cmd_len, bus.cmd_fixed} = cmd_q[0];
    else {bus.cmd_addr, bus.cmd_len, bus.cmd_fixed} = '0;
    bus.wd_nempty = (wd_q.size() != 0);
    if (wd_q.size() != 0) {bus.wd_data, bus.wd_last} = wd_q[0];
    else {bus.wd_data, bus.wd_last} = '0;
    #1;
    if (bus.bram_we === 1'b1) wr_log.push_back('{cyc, bus.bram_addr, bus.bram_wdata});
    if (bus.done === 1'b1) dn_log.push_back('{cyc, bus.err});
    if (cyc < 4096) busy_log[cyc] = bus.busy;
    if (bus.cmd_re === 1'b1) begin
      cre_log.push_back(cyc);
      if (cmd_q.size() == 0) bad_pop++;
      else void'(cmd_q.pop_front());
    end
    if (bus.wd_re === 1'b1) begin
      if (wd_q.size() == 0) bad_pop++;
      else void'(wd_q.pop_front());
    end
    if (bus.cmd_re === 1'b1 && bus.wd_re === 1'b1) overlap++;
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic clear_logs();
    wr_log.delete();
    dn_log.delete();
    cre_log.delete();
  endtask

  task automatic chk_wr(input string tag, input int i, input int ecyc,
                        input logic [AW-1:0] ea, input logic [DW-1:0] ed);
    if (i < wr_log.size()) begin
      check({tag, "_cyc"}, wr_log[i].cyc, ecyc);
      check({tag, "_addr"}, wr_log[i].addr, ea);
      check({tag, "_data"}, wr_log[i].data, ed);
    end else begin
      check({tag, "_missing"}, wr_log.size(), i + 1);
    end
  endtask

  task automatic chk_dn(input string tag, input int i, input int ecyc, input logic eerr);
    if (i < dn_log.size()) begin
      check({tag, "_cyc"}, dn_log[i].cyc, ecyc);
      check({tag, "_err"}, dn_log[i].err, eerr);
    end else begin
      check({tag, "_missing"}, dn_log.size(), i + 1);
    end
  endtask

  task automatic push_burst(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic f,
                            input logic [DW-1:0] base, input int last_idx);
    cmd_q.push_back({a, l, f});
    for (int i = 0; i <= int'(l); i++) wd_q.push_back({base + DW'(i), (i == last_idx)});
  endtask

  initial begin
    // Reset with a command and data already queued: nothing may be popped.
    push_burst(10'h010, 4'd3, 1'b0, 32'hA000_0000, 3);
    clear_logs();
    run(3);
    check("rst_no_cmd_re", cre_log.size(), 0);
    check("rst_wd_left", wd_q.size(), 4);
    check("rst_we", bus.bram_we, 1'b0);
    check("rst_addr", bus.bram_addr, 10'h000);
    check("rst_wdata", bus.bram_wdata, 32'h0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_err", bus.err, 1'b0);

    // INCR 0x010 len=3, data pre-filled.
    rst_v = 1'b0;
    clear_logs();
    k = cyc;
    run(8);
    check("t1_cre_n", cre_log.size(), 1);
    if (cre_log.size() > 0) check("t1_cre_cyc", cre_log[0], k);
    check("t1_wr_n", wr_log.size(), 4);
    for (int i = 0; i < 4; i++) chk_wr("t1_wr", i, k + 2 + i, 10'h010 + AW'(i), 32'hA000_0000 + DW'(i));
    check("t1_dn_n", dn_log.size(), 1);
    chk_dn("t1_dn", 0, k + 5, 1'b0);
    check("t1_busy_data", busy_log[k + 1], 1'b1);
    check("t1_busy_after", busy_log[k + 6], 1'b0);

    // FIXED at 0x3FF len=1.
    push_burst(10'h3FF, 4'd1, 1'b1, 32'hB000_0000, 1);
    clear_logs();
    k = cyc;
    run(6);
    check("t2_wr_n", wr_log.size(), 2);
    chk_wr("t2_wr0", 0, k + 2, 10'h3FF, 32'hB000_0000);
    chk_wr("t2_wr1", 1, k + 3, 10'h3FF, 32'hB000_0001);
    chk_dn("t2_dn", 0, k + 3, 1'b0);

    // INCR at 0x3FF len=1: wraps to 0x000.
    push_burst(10'h3FF, 4'd1, 1'b0, 32'hB100_0000, 1);
    clear_logs();
    k = cyc;
    run(6);
    check("t3_wr_n", wr_log.size(), 2);
    chk_wr("t3_wr0", 0, k + 2, 10'h3FF, 32'hB100_0000);
    chk_wr("t3_wr1", 1, k + 3, 10'h000, 32'hB100_0001);
    chk_dn("t3_dn", 0, k + 3, 1'b0);

    // INCR len=2 with the data FIFO empty for 5 cycles after beat 0.
    cmd_q.push_back({10'h100, 4'd2, 1'b0});
    wd_q.push_back({32'hC000_0000, 1'b0});
    clear_logs();
    k = cyc;
    run(3);
    run(5);
    wd_q.push_back({32'hC000_0001, 1'b0});
    wd_q.push_back({32'hC000_0002, 1'b1});
    run(6);
    check("t4_wr_n", wr_log.size(), 3);
    chk_wr("t4_wr0", 0, k + 2, 10'h100, 32'hC000_0000);
    chk_wr("t4_wr1", 1, k + 9, 10'h101, 32'hC000_0001);
    chk_wr("t4_wr2", 2, k + 10, 10'h102, 32'hC000_0002);
    check("t4_dn_n", dn_log.size(), 1);
    chk_dn("t4_dn", 0, k + 10, 1'b0);

    // len=2 with wd_last on beat 0 (early).
    push_burst(10'h050, 4'd2, 1'b0, 32'hD000_0000, 0);
    clear_logs();
    k = cyc;
    run(7);
    check("t5_wr_n", wr_log.size(), 3);
    chk_wr("t5_wr2", 2, k + 4, 10'h052, 32'hD000_0002);
    chk_dn("t5_dn", 0, k + 4, 1'b1);

    // len=2 with no wd_last at all.
    push_burst(10'h050, 4'd2, 1'b0, 32'hD100_0000, -1);
    clear_logs();
    k = cyc;
    run(7);
    check("t6_wr_n", wr_log.size(), 3);
    chk_wr("t6_wr2", 2, k + 4, 10'h052, 32'hD100_0002);
    chk_dn("t6_dn", 0, k + 4, 1'b1);

    // Clean single-beat burst clears the sticky error.
    push_burst(10'h060, 4'd0, 1'b0, 32'hD200_0000, 0);
    clear_logs();
    k = cyc;
    run(5);
    chk_wr("t7_wr0", 0, k + 2, 10'h060, 32'hD200_0000);
    chk_dn("t7_dn", 0, k + 2, 1'b0);

    // Reset after 2 of 8 beats; a queued command must wait for rst to drop.
    push_burst(10'h020, 4'd7, 1'b0, 32'hE000_0000, 7);
    clear_logs();
    k = cyc;
    run(3);
    rst_v = 1'b1;
    cmd_q.push_back({10'h040, 4'd5, 1'b0});
    run(4);
    check("t8_wr_n", wr_log.size(), 2);
    chk_wr("t8_wr1", 1, k + 3, 10'h021, 32'hE000_0001);
    check("t8_busy", busy_log[k + 4], 1'b0);
    check("t8_no_done", dn_log.size(), 0);
    check("t8_wd_left", wd_q.size(), 6);
    check("t8_cre_n", cre_log.size(), 1);
    check("t8_cmd_left", cmd_q.size(), 1);
    rst_v = 1'b0;
    clear_logs();
    k = cyc;
    run(10);
    check("t8b_wr_n", wr_log.size(), 6);
    for (int i = 0; i < 6; i++) chk_wr("t8b_wr", i, k + 2 + i, 10'h040 + AW'(i), 32'hE000_0002 + DW'(i));
    chk_dn("t8b_dn", 0, k + 7, 1'b0);

    // Two back-to-back single-beat commands.
    push_burst(10'h070, 4'd0, 1'b0, 32'hF000_0000, 0);
    push_burst(10'h075, 4'd0, 1'b1, 32'hF100_0000, 0);
    clear_logs();
    k = cyc;
    run(8);
    check("t9_cre_n", cre_log.size(), 2);
    if (cre_log.size() > 0) check("t9_cre0", cre_log[0], k);
    if (cre_log.size() > 1) check("t9_cre1", cre_log[1], k + 3);
    chk_wr("t9_wr0", 0, k + 2, 10'h070, 32'hF000_0000);
    chk_wr("t9_wr1", 1, k + 5, 10'h075, 32'hF100_0000);
    chk_dn("t9_dn0", 0, k + 2, 1'b0);
    chk_dn("t9_dn1", 1, k + 5, 1'b0);

    // len all-ones: 16 beats.
    push_burst(10'h200, 4'hF, 1'b0, 32'h5500_0000, 15);
    clear_logs();
    k = cyc;
    run(20);
    check("t10_wr_n", wr_log.size(), 16);
    for (int i = 0; i < 16; i++) chk_wr("t10_wr", i, k + 2 + i, 10'h200 + AW'(i), 32'h5500_0000 + DW'(i));
    check("t10_dn_n", dn_log.size(), 1);
    chk_dn("t10_dn", 0, k + 17, 1'b0);
    check("t10_busy_after", busy_log[k + 18], 1'b0);

    check("pop_overlap", overlap, 0);
    check("pop_when_empty", bad_pop, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
